sram_like_bridge: RTL

SRAM_LIKE_BRIDGE -- requirements
Module: sram_like_bridge

---
 rtl/sram_like_bridge.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sram_like_bridge.sv
// Round-robin bridge from N SRAM-like requesters onto one SRAM port.
// Ports: port_* requester side (req/wr/size/addr/wdata in; addr_ok/data_ok/rdata/err out), sram_* memory side.
module sram_like_bridge #(
  parameter int NUM_PORTS = 2,
  parameter int LATENCY   = 1,
  parameter int ADDR_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        port_req,
  input  logic [NUM_PORTS-1:0]        port_wr,
  input  logic [2*NUM_PORTS-1:0]      port_size,
  input  logic [ADDR_W*NUM_PORTS-1:0] port_addr,
  input  logic [32*NUM_PORTS-1:0]     port_wdata,
  output logic [NUM_PORTS-1:0]        port_addr_ok,
  output logic [NUM_PORTS-1:0]        port_data_ok,
  output logic [31:0]                 port_rdata,
  output logic                        port_err,
  output logic                        sram_en,
  output logic [3:0]                  sram_wen,
  output logic [ADDR_W-1:0]           sram_addr,
  output logic [31:0]                 sram_wdata,
  input  logic [31:0]                 sram_rdata
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  logic [ADDR_W-1:0] addr_a  [NUM_PORTS];
  logic [1:0]        size_a  [NUM_PORTS];
  logic [31:0]       wdata_a [NUM_PORTS];

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_unpack
    assign addr_a[k]  = port_addr[k*ADDR_W +: ADDR_W];
    assign size_a[k]  = port_size[2*k +: 2];
    assign wdata_a[k] = port_wdata[32*k +: 32];
  end

  idx_t ptr_q, ptr_d;
  logic vld_q  [LATENCY];
  logic vld_d  [LATENCY];
  idx_t pidx_q [LATENCY];
  idx_t pidx_d [LATENCY];
  logic perr_q [LATENCY];
  logic perr_d [LATENCY];

  logic              gnt_any;
  idx_t              gnt_idx;
  idx_t              scan_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_size;
  logic              sel_err;
  logic              dok;

  // Scan from the priority pointer; first requester wins.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan_idx = idx_t'((int'(ptr_q) + i) % NUM_PORTS);
      if (!gnt_any && port_req[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    if (rst) gnt_any = 1'b0;
  end

  always_comb begin
    sel_addr = addr_a[gnt_idx];
    sel_size = size_a[gnt_idx];
    sel_err  = 1'b0;
    unique case (1'b1)
      sel_size == 2'd3:                   sel_err = 1'b1;
      sel_size == 2'd1 && sel_addr[0]:    sel_err = 1'b1;
      sel_size == 2'd2 && |sel_addr[1:0]: sel_err = 1'b1;
      default:                            sel_err = 1'b0;
    endcase
  end

  always_comb begin
    sram_en    = gnt_any;
    sram_addr  = {sel_addr[ADDR_W-1:2], 2'b00};
    sram_wdata = wdata_a[gnt_idx];
    sram_wen   = 4'b0000;
    if (gnt_any && port_wr[gnt_idx] && !sel_err) begin
      unique case (sel_size)
        2'd0:    sram_wen = 4'b0001 << sel_addr[1:0];
        2'd1:    sram_wen = 4'b0011 << sel_addr[1:0];
        default: sram_wen = 4'b1111;
      endcase
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any)
      ptr_d = (gnt_idx == idx_t'(NUM_PORTS - 1)) ? '0 : gnt_idx + idx_t'(1);
  end

  always_comb begin
    vld_d  = vld_q;
    pidx_d = pidx_q;
    perr_d = perr_q;
    vld_d[0]  = gnt_any;
    pidx_d[0] = gnt_idx;
    perr_d[0] = sel_err;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      pidx_d[i] = pidx_q[i-1];
      perr_d[i] = perr_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i]  <= 1'b0;
        pidx_q[i] <= '0;
        perr_q[i] <= 1'b0;
      end
    end else begin
      ptr_q  <= ptr_d;
      vld_q  <= vld_d;
      pidx_q <= pidx_d;
      perr_q <= perr_d;
    end
  end

  always_comb begin
    dok          = vld_q[LATENCY-1] && !rst;
    port_addr_ok = gnt_any ? (NUM_PORTS'(1) << gnt_idx) : '0;
    port_data_ok = dok ? (NUM_PORTS'(1) << pidx_q[LATENCY-1]) : '0;
    port_err     = dok && perr_q[LATENCY-1];
    port_rdata   = sram_rdata;
  end

endmodule
